// File: rtl/sicaklik_pkg.sv
// Shared definitions for the temperature alarm scan controller.
//   state_t        : scan FSM states (IDLE, SCAN, DONE)
//   W_DEF          : default temperature/limit width
//   LIMIT_RST_BIT  : bit replicated across the limit register at reset (all ones)
//   ch_w()         : width of a channel index for n channels (minimum 1 bit)
// Optional build macro used by the design: HYSTERESIS_EN
package sicaklik_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int W_DEF = 3;

   localparam logic LIMIT_RST_BIT = 1'b1;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/esik_karsilastirici.sv
// Threshold comparator shared by all scan channels. Pure combinational.
// Ports:
//   temp        in  W  temperature of the channel under comparison
//   limit       in  W  current alarm limit
//   hyst        in  W  hysteresis band width (only with HYSTERESIS_EN)
//   over        out 1  temp >= limit
//   below_band  out 1  sample low enough to clear the debounce counter
// Build macro: HYSTERESIS_EN adds the hyst port and the hold band
//   [limit-hyst, limit); without it every sample below limit clears.
module esik_karsilastirici #(
   parameter int W = 3
) (
   input  logic [W-1:0] temp,
   input  logic [W-1:0] limit,
`ifdef HYSTERESIS_EN
   input  logic [W-1:0] hyst,
`endif
   output logic         over,
   output logic         below_band
);

   assign over = (temp >= limit);

`ifdef HYSTERESIS_EN
   logic [W-1:0] band_lo;

   // Lower band edge saturates at zero instead of wrapping.
   assign band_lo    = (limit >= hyst) ? (limit - hyst) : '0;
   assign below_band = (temp < band_lo);
`else
   assign below_band = ~over;
`endif

endmodule

// File: rtl/sicaklik_alarm_ctrl.sv
// Multi-sensor temperature scan controller. One shared comparator is walked
// across N_CH channels, one per clock; per-channel debounce counters raise a
// latched alarm after DEB consecutive samples at or above the limit.
// Ports:
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             synchronous active-low reset
//   run          in   1             scan enable (level)
//   sicaklik_in  in   N_CH*W        packed temperatures, channel k = [k*W +: W]
//   cfg_we       in   1             limit write strobe, honoured only in IDLE
//   cfg_limit    in   W             new limit value
//   ack          in   N_CH          per-channel alarm clear
//   ch_sel       out  ch_w(N_CH)    channel under comparison
//   alarm        out  N_CH          latched per-channel alarm
//   alarm_any    out  1             OR of alarm
//   busy         out  1             high in SCAN and DONE
//   scan_done    out  1             one-cycle pulse after the last channel
// Build macro: HYSTERESIS_EN enables the HYST hold band in the comparator.
module sicaklik_alarm_ctrl
   import sicaklik_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = W_DEF,
   parameter int DEB  = 3,
   parameter int HYST = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic [N_CH*W-1:0]       sicaklik_in,
   input  logic                    cfg_we,
   input  logic [W-1:0]            cfg_limit,
   input  logic [N_CH-1:0]         ack,
   output logic [ch_w(N_CH)-1:0]   ch_sel,
   output logic [N_CH-1:0]         alarm,
   output logic                    alarm_any,
   output logic                    busy,
   output logic                    scan_done
);

   localparam int                CH_W    = ch_w(N_CH);
   localparam int                CNT_W   = $clog2(DEB + 1);
   localparam logic [CNT_W-1:0]  DEB_C   = CNT_W'(DEB);
   localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [W-1:0]     limit;
   logic [W-1:0]     temp;
   logic [CNT_W-1:0] cnt [N_CH];
   logic [CNT_W-1:0] cnt_cur;
   logic [CNT_W-1:0] cnt_upd;
   logic [N_CH-1:0]  hit;
   logic             over;
   logic             below_band;
   logic             set_now;

   assign temp    = sicaklik_in[int'(ch_sel) * W +: W];
   assign cnt_cur = cnt[ch_sel];

   esik_karsilastirici #(.W(W)) u_esik (
      .temp       (temp),
      .limit      (limit),
`ifdef HYSTERESIS_EN
      .hyst       (W'(HYST)),
`endif
      .over       (over),
      .below_band (below_band)
   );

`ifndef HYSTERESIS_EN
   // No hold band in this build; HYST is accepted but has no effect.
   if (HYST < 0) begin : g_hyst_unused
   end
`endif

   // Next state, status outputs and the shared counter update for ch_sel.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      scan_done = 1'b0;
      hit       = '0;
      cnt_upd   = cnt_cur;
      case (state)
         IDLE: begin
            if (run) state_nxt = SCAN;
         end
         SCAN: begin
            busy        = 1'b1;
            hit[ch_sel] = 1'b1;
            if (ch_sel == LAST_CH) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            scan_done = 1'b1;
            state_nxt = run ? SCAN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Counter saturates at DEB; samples inside the hold band keep it.
      if (over)            cnt_upd = (cnt_cur == DEB_C) ? DEB_C : cnt_cur + 1'b1;
      else if (below_band) cnt_upd = '0;
   end

   assign set_now   = over && (cnt_upd == DEB_C);
   assign alarm_any = |alarm;

   // Control registers: state, channel pointer, limit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         ch_sel <= '0;
         limit  <= {W{LIMIT_RST_BIT}};
      end else begin
         state  <= state_nxt;
         ch_sel <= (state == SCAN && ch_sel != LAST_CH) ? ch_sel + 1'b1 : '0;
         if (cfg_we && state == IDLE) limit <= cfg_limit;
      end
   end

   // Debounce counters and latched alarms; a set event beats ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
         alarm <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (hit[k] && set_now) begin
               cnt[k]   <= cnt_upd;
               alarm[k] <= 1'b1;
            end else if (ack[k]) begin
               cnt[k]   <= '0;
               alarm[k] <= 1'b0;
            end else if (hit[k]) begin
               cnt[k]   <= cnt_upd;
            end
         end
      end
   end

endmodule
